// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields and a full immediate into a
// 32-bit instruction word. It range/alignment-checks the immediate, tags
// each word with a sequential byte address, and queues the result in a
// small in-order FIFO with valid/ready on both sides.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          ERRW      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [31:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [31:0]     out_addr,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Inclusive signed range test for immediates.
  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + {{(ERRW-1){1'b0}}, 1'b1};
  endfunction

  logic signed [31:0] imm_s;
  logic [31:0]        enc_instr;
  logic               enc_err;
  logic               imm_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     addr_q, addr_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            full, empty, accept, pop, wr_en;

  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_addr_q  [DEPTH];
  logic        mem_err_q   [DEPTH];

  assign imm_s = signed'(in_imm);

  // Format-specific packing and immediate legality; failures become a NOP.
  always_comb begin
    imm_ok    = 1'b1;
    enc_instr = NOP;
    case (in_fmt)
      3'd0: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: begin
        imm_ok    = in_range(imm_s, -32'sd2048, 32'sd2047);
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      3'd2: begin
        imm_ok    = in_range(imm_s, -32'sd2048, 32'sd2047);
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      3'd3: begin
        imm_ok    = in_range(imm_s, -32'sd4096, 32'sd4094) && !in_imm[0];
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      end
      3'd4: begin
        imm_ok    = (in_imm[11:0] == 12'd0);
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
      end
      3'd5: begin
        imm_ok    = in_range(imm_s, -32'sd1048576, 32'sd1048574) && !in_imm[0];
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, in_opcode};
      end
      default: imm_ok = 1'b0;
    endcase
    enc_err = !imm_ok;
    if (enc_err) enc_instr = NOP;
  end

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Handshakes are held off while reset is asserted.
  assign in_ready  = rst_n && !full;
  assign out_valid = rst_n && !empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_en     = accept && !clear;

  // Next-state for pointers, address counter and error counter; clear wins.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      addr_d    = BASE_ADDR;
      err_cnt_d = '0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        addr_d   = addr_q + 32'd4;
        if (enc_err) err_cnt_d = sat_inc(err_cnt_q);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      addr_q    <= BASE_ADDR;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_instr_q[wr_ptr_q[AW-1:0]] <= enc_instr;
      mem_addr_q[wr_ptr_q[AW-1:0]]  <= addr_q;
      mem_err_q[wr_ptr_q[AW-1:0]]   <= enc_err;
    end
  end

  // Head outputs read zero whenever the FIFO presents nothing.
  always_comb begin
    out_instr = '0;
    out_addr  = '0;
    out_err   = 1'b0;
    if (out_valid) begin
      out_instr = mem_instr_q[rd_ptr_q[AW-1:0]];
      out_addr  = mem_addr_q[rd_ptr_q[AW-1:0]];
      out_err   = mem_err_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder. Expected words are
// queued at accept time and compared as the FIFO head is consumed.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr, out_addr;
  logic [15:0] err_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_addr;
  int          err_model;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(2), .ERRW(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Compare every head that is consumed against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check_eq("sb_nonempty_on_pop", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("out_instr", out_instr, e.instr);
        check_eq("out_addr", out_addr, e.addr);
        check_eq("out_err", out_err, e.err);
      end
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        sb_q.push_back('{instr: exp_instr, addr: exp_addr, err: exp_err});
        exp_addr = exp_addr + 32'd4;
        if (exp_err && err_model < 65535) err_model++;
      end
    end
    check_eq("accept_within_budget", ok, 1);
    if (ok) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("valid_after_accept", out_valid, 1);
      check_eq("err_count", err_count, err_model);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(negedge clk);
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_instr"}, out_instr, 0);
    check_eq({tag, "_out_addr"}, out_addr, 0);
    check_eq({tag, "_out_err"}, out_err, 0);
    check_eq({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    exp_addr = BASE; err_model = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", in_ready, 1);

    // One of each format plus range boundaries; addresses wrap past 0xFFFFFFFC.
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      32'h7FF0_0093, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,      32'h7E00_0FE3, 1'b0);

    // Illegal immediates and formats become NOP with the error flag.
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0000_0013, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'h0000_0013, 1'b1);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 1'b1);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,   32'h0000_0013, 1'b1);
    drain();

    // Backpressure: two entries fill the FIFO, the third waits.
    out_ready = 1'b0;
    fork
      begin
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0113, 1'b0);
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0193, 1'b0);
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0213, 1'b0);
      end
      begin
        repeat (8) @(negedge clk);
        check_eq("bp_in_ready_low", in_ready, 0);
        check_eq("bp_head_instr", out_instr, 32'h0010_0113);
        check_eq("bp_head_addr", out_addr, sb_q[0].addr);
        repeat (3) @(negedge clk);
        check_eq("bp_head_instr_stable", out_instr, 32'h0010_0113);
        check_eq("bp_head_addr_stable", out_addr, sb_q[0].addr);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Clear with two entries queued and a tuple offered in the same cycle.
    out_ready = 1'b0;
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1;
    drive(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    sb_q.delete(); exp_addr = BASE; err_model = 0;
    @(negedge clk);
    check_eq("clr_out_valid", out_valid, 0);
    check_eq("clr_in_ready", in_ready, 1);
    check_eq("clr_err_count", err_count, 0);
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h0060_0093, 1'b0);
    drain();

    // Reset mid-stream with a full FIFO.
    out_ready = 1'b0;
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0093, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready_low", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    sb_q.delete(); exp_addr = BASE; err_model = 0;
    @(negedge clk);
    check_eq("rst_ready_after_release", in_ready, 1);
    check_eq("rst_empty_after_release", out_valid, 0);
    out_ready = 1'b1;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
